// File: rtl/addsub_result_buffer.sv
// addsub_result_buffer
//
// Sits after the VFU vector add/sub stage of the LN datapath. The add/sub IP
// has no back-pressure on its result side. This block therefore gates the
// IP's issue enable with a credit check. Each issued op is tracked through a
// {valid, tag} pipeline whose length matches the IP latency. The result
// vector is captured into a first-word-fall-through FIFO when the op
// emerges, and the FIFO is offered to the next LN stage.
//
// Handshakes (both sides): a transfer happens on a rising clk edge exactly
// when the producer's valid and the consumer's ready are both high in the
// cycle before that edge. Valid never depends on ready. Ready (issue_ready)
// depends only on registers.
//
// Ports
//   clk          single clock, rising edge
//   rst          asynchronous, active-low reset
//   issue_valid  upstream wants to issue an add/sub this cycle
//   issue_tag    sideband tag carried with the op
//   issue_ready  a credit is free (FIFO occupancy + in-flight ops < DEPTH)
//   addsub_en    issue_valid && issue_ready; drives the add/sub stage enable
//   res_vec      add/sub stage result vector
//   out_valid    FIFO non-empty (registered)
//   out_ready    consumer accepts the head entry
//   out_vec      head result, 0 when empty
//   out_tag      head tag, 0 when empty
//   count        FIFO occupancy (registered)
//   overflow     sticky: a write arrived while full with no pop
module addsub_result_buffer #(
    parameter int N       = 4,
    parameter int WIDTH   = 16,
    parameter int LATENCY = 8,
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       issue_valid,
    input  logic [TAG_W-1:0]           issue_tag,
    output logic                       issue_ready,
    output logic                       addsub_en,
    input  logic [N*WIDTH-1:0]         res_vec,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [N*WIDTH-1:0]         out_vec,
    output logic [TAG_W-1:0]           out_tag,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow
);

    localparam int VW = N * WIDTH;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int IW = $clog2(LATENCY + 1);
    // Wide enough to hold count + inflight without wrapping.
    localparam int SW = ((CW > IW) ? CW : IW) + 1;

    // Latency-matched tracking pipeline. Bit LATENCY-1 is the stage whose
    // result is on res_vec in the current cycle.
    logic [LATENCY-1:0] pipe_valid_q, pipe_valid_d;
    logic [TAG_W-1:0]   pipe_tag_q [LATENCY];
    logic [TAG_W-1:0]   pipe_tag_d [LATENCY];
    logic [IW-1:0]      inflight_q, inflight_d;

    // FIFO storage and bookkeeping.
    logic [VW-1:0]      mem_vec_q [DEPTH];
    logic [VW-1:0]      mem_vec_d [DEPTH];
    logic [TAG_W-1:0]   mem_tag_q [DEPTH];
    logic [TAG_W-1:0]   mem_tag_d [DEPTH];
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               out_valid_q, out_valid_d;
    logic               overflow_q, overflow_d;

    logic               fire;
    logic               wr_en;
    logic               wr_accept;
    logic               pop;
    logic               full;
    logic [SW-1:0]      credit_used;

    // Credits come only from registered state. A pop in this cycle frees its
    // slot for the next cycle, not this one.
    assign credit_used = SW'(count_q) + SW'(inflight_q);
    assign issue_ready = (credit_used < SW'(DEPTH));
    assign fire        = issue_valid && issue_ready;
    assign addsub_en   = fire;

    assign wr_en = pipe_valid_q[LATENCY-1];
    assign pop   = out_valid_q && out_ready;
    assign full  = (count_q == CW'(DEPTH));
    // A write into a full FIFO only lands if the head leaves at the same edge.
    assign wr_accept = wr_en && (!full || pop);

    assign out_valid = out_valid_q;
    assign out_vec   = out_valid_q ? mem_vec_q[rd_ptr_q] : '0;
    assign out_tag   = out_valid_q ? mem_tag_q[rd_ptr_q] : '0;
    assign count     = count_q;
    assign overflow  = overflow_q;

    always_comb begin
        pipe_valid_d = '0;
        for (int i = 0; i < LATENCY; i++) begin
            pipe_tag_d[i] = '0;
        end
        pipe_valid_d[0] = fire;
        pipe_tag_d[0]   = issue_tag;
        for (int i = 1; i < LATENCY; i++) begin
            pipe_valid_d[i] = pipe_valid_q[i-1];
            pipe_tag_d[i]   = pipe_tag_q[i-1];
        end

        // Counter instead of a popcount: one enters per fire, one leaves per
        // emerging result.
        inflight_d = inflight_q + IW'(fire) - IW'(wr_en);
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_vec_d[i] = mem_vec_q[i];
            mem_tag_d[i] = mem_tag_q[i];
        end
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (wr_accept) begin
            mem_vec_d[wr_ptr_q] = res_vec;
            mem_tag_d[wr_ptr_q] = pipe_tag_q[LATENCY-1];
            wr_ptr_d            = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        case ({wr_accept, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (wr_en && full && !pop) begin
            overflow_d = 1'b1;
        end

        out_valid_d = (count_d != '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_valid_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_tag_q[i] <= '0;
            end
            inflight_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_vec_q[i] <= '0;
                mem_tag_q[i] <= '0;
            end
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            pipe_valid_q <= pipe_valid_d;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_tag_q[i] <= pipe_tag_d[i];
            end
            inflight_q <= inflight_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_vec_q[i] <= mem_vec_d[i];
                mem_tag_q[i] <= mem_tag_d[i];
            end
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
        end
    end

endmodule

// File: tb/tb_addsub_result_buffer.sv
module tb_addsub_result_buffer;

    localparam int N       = 4;
    localparam int WIDTH   = 16;
    localparam int LATENCY = 8;
    localparam int DEPTH   = 4;
    localparam int TAG_W   = 4;
    localparam int VW      = N * WIDTH;
    localparam int CW      = $clog2(DEPTH + 1);

    logic              clk;
    logic              rst;
    logic              issue_valid;
    logic [TAG_W-1:0]  issue_tag;
    logic              issue_ready;
    logic              addsub_en;
    logic [VW-1:0]     res_vec;
    logic              out_valid;
    logic              out_ready;
    logic [VW-1:0]     out_vec;
    logic [TAG_W-1:0]  out_tag;
    logic [CW-1:0]     count;
    logic              overflow;

    int total;
    int bad;

    logic [TAG_W+VW-1:0] exp_q[$];

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [VW-1:0]    vec;
        logic [VW-1:0]    exp_vec;
        logic [TAG_W-1:0] exp_tag;
    } vec_t;

    vec_t tbl[6];

    addsub_result_buffer #(
        .N(N), .WIDTH(WIDTH), .LATENCY(LATENCY), .DEPTH(DEPTH), .TAG_W(TAG_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .issue_valid(issue_valid),
        .issue_tag(issue_tag),
        .issue_ready(issue_ready),
        .addsub_en(addsub_en),
        .res_vec(res_vec),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_vec(out_vec),
        .out_tag(out_tag),
        .count(count),
        .overflow(overflow)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: act=timeout req=finish");
        $fatal(1, "watchdog expired");
    end

    // driver helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: act=%0h req=%0h", name, act, exp);
        end
    endtask

    // Distinct, never-zero pattern for the result presented at a given step.
    function automatic logic [VW-1:0] pat(input int e);
        logic [15:0] v;
        v = 16'(e);
        return {v, v, v, v} ^ 64'hA5A5_3C3C_0F0F_F0F0;
    endfunction

    // Stream schedule: with out_ready held high, each op frees its credit
    // one cycle after its pop (issue at t, pop at t+9, reissue at t+10), so
    // fires land in bursts of 4 every 10 edges.
    function automatic bit stream_fire_at(input int e);
        return (e >= 0) && (e < 36) && ((e % 10) < 4);
    endfunction

    initial begin
        int fires;
        int pops;
        int nfire;
        logic [TAG_W+VW-1:0] exp_e;

        total       = 0;
        bad         = 0;
        rst         = 1'b0;
        issue_valid = 1'b0;
        issue_tag   = '0;
        res_vec     = '0;
        out_ready   = 1'b0;

        tbl[0] = '{tag: 4'd3,  vec: 64'h3C00_4000_4200_4400, exp_vec: 64'h3C00_4000_4200_4400, exp_tag: 4'd3};
        tbl[1] = '{tag: 4'd0,  vec: 64'h0000_0000_0000_0001, exp_vec: 64'h0000_0000_0000_0001, exp_tag: 4'd0};
        tbl[2] = '{tag: 4'd15, vec: 64'hFFFF_FFFF_FFFF_FFFF, exp_vec: 64'hFFFF_FFFF_FFFF_FFFF, exp_tag: 4'd15};
        tbl[3] = '{tag: 4'd9,  vec: 64'h8000_7C00_FC00_0400, exp_vec: 64'h8000_7C00_FC00_0400, exp_tag: 4'd9};
        tbl[4] = '{tag: 4'd6,  vec: 64'h1234_5678_9ABC_DEF0, exp_vec: 64'h1234_5678_9ABC_DEF0, exp_tag: 4'd6};
        tbl[5] = '{tag: 4'd10, vec: 64'hC000_BC00_3800_0000, exp_vec: 64'hC000_BC00_3800_0000, exp_tag: 4'd10};

        // ---- reset values ----
        #3;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_vec",   64'(out_vec),   64'd0);
        check("rst_out_tag",   64'(out_tag),   64'd0);
        check("rst_count",     64'(count),     64'd0);
        check("rst_overflow",  64'(overflow),  64'd0);
        issue_valid = 1'b1;
        #1;
        check("rst_issue_ready", 64'(issue_ready), 64'd1);
        check("rst_addsub_en",   64'(addsub_en),   64'd1);
        issue_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;

        // ---- single ops from the table ----
        for (int k = 0; k < 6; k++) begin
            issue_valid = 1'b1;
            issue_tag   = tbl[k].tag;
            res_vec     = ~tbl[k].vec;
            #1;
            check("single_en", 64'(addsub_en), 64'd1);
            tick();                              // fire edge 0
            issue_valid = 1'b0;
            for (int j = 1; j < LATENCY; j++) tick();
            #1;
            check("single_early_valid", 64'(out_valid), 64'd0);
            res_vec = tbl[k].vec;
            tick();                              // write edge LATENCY
            res_vec = ~tbl[k].vec;
            #1;
            check("single_valid", 64'(out_valid), 64'd1);
            check("single_vec",   64'(out_vec),   64'(tbl[k].exp_vec));
            check("single_tag",   64'(out_tag),   64'(tbl[k].exp_tag));
            check("single_count", 64'(count),     64'd1);
            out_ready = 1'b1;
            tick();                              // pop edge
            out_ready = 1'b0;
            #1;
            check("single_pop_valid", 64'(out_valid), 64'd0);
            check("single_pop_vec",   64'(out_vec),   64'd0);
            check("single_pop_count", 64'(count),     64'd0);
        end

        // ---- credit exhaustion and refused issue ----
        fires     = 0;
        out_ready = 1'b0;
        for (int e = 0; e <= 20; e++) begin
            int filled;
            // Writes land at edges 8..11; occupancy after edge e-1.
            filled = (e - 1) - (LATENCY - 1);
            if (filled < 0) filled = 0;
            if (filled > 4) filled = 4;
            check("credit_count", 64'(count), 64'(filled));
            issue_valid = 1'b1;
            issue_tag   = 4'(e);
            res_vec     = pat(e);
            #1;
            check("credit_ready", 64'(issue_ready), 64'(e < 4));
            check("credit_en",    64'(addsub_en),   64'(e < 4));
            if (addsub_en) fires++;
            tick();
        end
        issue_valid = 1'b0;
        #1;
        check("credit_fires",    64'(fires),    64'd4);
        check("credit_count4",   64'(count),    64'd4);
        check("credit_overflow", 64'(overflow), 64'd0);
        out_ready = 1'b1;
        #1;
        check("credit_ready_in_pop_cycle", 64'(issue_ready), 64'd0);
        check("credit_head_vec", 64'(out_vec), 64'(pat(8)));
        check("credit_head_tag", 64'(out_tag), 64'd0);
        tick();
        out_ready = 1'b0;
        #1;
        check("credit_ready_after_pop", 64'(issue_ready), 64'd1);
        check("credit_count3",          64'(count),       64'd3);
        out_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            #1;
            check("credit_drain_vec", 64'(out_vec), 64'(pat(8 + k)));
            check("credit_drain_tag", 64'(out_tag), 64'(k));
            tick();
        end
        out_ready = 1'b0;
        #1;
        check("credit_drained", 64'(count), 64'd0);

        // ---- streaming with scoreboard ----
        exp_q.delete();
        fires = 0;
        pops  = 0;
        nfire = 0;
        out_ready = 1'b1;
        for (int e = 0; e < 46; e++) begin
            issue_valid = (e < 36);
            issue_tag   = 4'(nfire);
            res_vec     = pat(e + 100);
            #1;
            check("stream_en",    64'(addsub_en), 64'(stream_fire_at(e)));
            check("stream_valid", 64'(out_valid), 64'(stream_fire_at(e - (LATENCY + 1))));
            if (addsub_en) fires++;
            if (out_valid) begin
                pops++;
                if (exp_q.size() == 0) begin
                    check("stream_unexpected", 64'(out_tag), 64'hFFFF);
                end else begin
                    exp_e = exp_q.pop_front();
                    check("stream_tag", 64'(out_tag), 64'(exp_e[TAG_W+VW-1:VW]));
                    check("stream_vec", 64'(out_vec), 64'(exp_e[VW-1:0]));
                end
            end
            if (stream_fire_at(e)) begin
                exp_q.push_back({4'(nfire), pat(e + LATENCY + 100)});
                nfire++;
            end
            tick();
        end
        out_ready   = 1'b0;
        issue_valid = 1'b0;
        #1;
        check("stream_fires",  64'(fires),         64'd16);
        check("stream_pops",   64'(pops),          64'd16);
        check("stream_left",   64'(exp_q.size()),  64'd0);
        check("stream_count",  64'(count),         64'd0);

        // ---- simultaneous write and pop at count 2, across pointer wrap ----
        for (int e = 0; e < 14; e++) begin
            int popped;
            issue_valid = (e < 4);
            issue_tag   = 4'(8 + e);
            res_vec     = pat(e + 200);
            out_ready   = (e >= 10);
            #1;
            check("sim_en", 64'(addsub_en), 64'(e < 4));
            popped = (e - 1 >= 10) ? (e - 10) : 0;
            if (e == 9)  check("sim_count", 64'(count), 64'd1);
            if (e >= 10 && e <= 12) check("sim_count_hold", 64'(count), 64'd2);
            if (e == 13) check("sim_count", 64'(count), 64'd1);
            if (e >= 9) begin
                check("sim_head_tag", 64'(out_tag), 64'(8 + popped));
                check("sim_head_vec", 64'(out_vec), 64'(pat(8 + popped + 200)));
            end
            tick();
        end
        out_ready   = 1'b0;
        issue_valid = 1'b0;
        #1;
        check("sim_empty_count", 64'(count),     64'd0);
        check("sim_empty_valid", 64'(out_valid), 64'd0);

        // ---- reset mid-flight ----
        for (int e = 0; e <= 8; e++) begin
            issue_valid = (e == 0) || (e == 5) || (e == 6) || (e == 7);
            issue_tag   = 4'(e);
            res_vec     = pat(e + 300);
            #1;
            tick();
        end
        issue_valid = 1'b0;
        #1;
        check("mid_pre_count", 64'(count), 64'd1);
        rst = 1'b0;
        #1;
        check("mid_rst_valid",    64'(out_valid),   64'd0);
        check("mid_rst_count",    64'(count),       64'd0);
        check("mid_rst_vec",      64'(out_vec),     64'd0);
        check("mid_rst_tag",      64'(out_tag),     64'd0);
        check("mid_rst_overflow", 64'(overflow),    64'd0);
        check("mid_rst_ready",    64'(issue_ready), 64'd1);
        tick();
        rst = 1'b1;
        for (int e = 0; e < 10; e++) begin
            res_vec = pat(e + 400);
            #1;
            check("mid_stale_valid", 64'(out_valid), 64'd0);
            check("mid_stale_count", 64'(count),     64'd0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
